// File: rtl/code_loader_pkg.sv
// Shared constants and state encoding for the byte-stream code loader.
// Imported by the loader top and its idle timer.
package code_loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         MAX_WORDS_DEF = 512;
   localparam int         TIMEOUT_DEF   = 1_000_000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN_HI  = 3'd1,
      LEN_LO  = 3'd2,
      DATA_HI = 3'd3,
      DATA_LO = 3'd4,
      CHECK   = 3'd5,
      DONE    = 3'd6,
      ERROR   = 3'd7
   } state_e;

endpackage

// File: rtl/code_loader_timer.sv
// Idle-cycle counter for the loader: counts clocks without a byte strobe
// while enabled, and flags the edge on which the count reaches TIMEOUT.
module loader_timer #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count_q;

   // expired means "the coming edge is idle cycle number TIMEOUT"
   assign expired = enable && (count_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear || !enable) begin
         count_q <= '0;
      end else if (!expired) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/code_loader.sv
// Framed byte-stream loader: assembles 16-bit words into code memory,
// checks an XOR checksum, then releases the processor via run.
module code_loader
   import code_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_WORDS = MAX_WORDS_DEF,
   parameter int         TIMEOUT   = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        code_w_en,
   output logic [8:0]  code_addr_in,
   output logic [15:0] code_in,
   output logic        run,
   output logic        loading,
   output logic        err
);

   state_e      state_q;
   logic [7:0]  len_hi_q;
   logic [9:0]  len_q;
   logic [9:0]  words_q;
   logic [8:0]  addr_q;
   logic [7:0]  acc_q;
   logic [7:0]  hi_q;
   logic        code_w_en_q;
   logic [8:0]  code_addr_q;
   logic [15:0] code_in_q;
   logic        run_q;
   logic        loading_q;
   logic        err_q;

   logic [15:0] len_full;
   logic        len_ok;
   logic [9:0]  words_inc;
   logic        timer_expired;

   assign len_full  = {len_hi_q, rx_data};
   assign len_ok    = (len_full != 16'd0) && (len_full <= 16'(MAX_WORDS));
   assign words_inc = words_q + 10'd1;

   loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_valid),
      .enable  (loading_q),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_hi_q    <= '0;
         len_q       <= '0;
         words_q     <= '0;
         addr_q      <= '0;
         acc_q       <= '0;
         hi_q        <= '0;
         code_w_en_q <= 1'b0;
         code_addr_q <= '0;
         code_in_q   <= '0;
         run_q       <= 1'b0;
         loading_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         code_w_en_q <= 1'b0;
         if (rx_valid) begin
            unique case (state_q)
               IDLE, DONE, ERROR: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_q   <= LEN_HI;
                     run_q     <= 1'b0;
                     err_q     <= 1'b0;
                     loading_q <= 1'b1;
                     addr_q    <= '0;
                     words_q   <= '0;
                     acc_q     <= '0;
                  end
               end
               LEN_HI: begin
                  len_hi_q <= rx_data;
                  acc_q    <= acc_q ^ rx_data;
                  state_q  <= LEN_LO;
               end
               LEN_LO: begin
                  len_q <= len_full[9:0];
                  acc_q <= acc_q ^ rx_data;
                  if (len_ok) begin
                     state_q <= DATA_HI;
                  end else begin
                     state_q   <= ERROR;
                     err_q     <= 1'b1;
                     loading_q <= 1'b0;
                  end
               end
               DATA_HI: begin
                  hi_q    <= rx_data;
                  acc_q   <= acc_q ^ rx_data;
                  state_q <= DATA_LO;
               end
               DATA_LO: begin
                  acc_q       <= acc_q ^ rx_data;
                  code_w_en_q <= 1'b1;
                  code_addr_q <= addr_q;
                  code_in_q   <= {hi_q, rx_data};
                  addr_q      <= addr_q + 9'd1;
                  words_q     <= words_inc;
                  state_q     <= (words_inc == len_q) ? CHECK : DATA_HI;
               end
               CHECK: begin
                  loading_q <= 1'b0;
                  if (rx_data == acc_q) begin
                     state_q <= DONE;
                     run_q   <= 1'b1;
                  end else begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end
            endcase
         end else if (timer_expired) begin
            // a byte on the expiry edge takes priority, hence the else
            state_q   <= ERROR;
            err_q     <= 1'b1;
            loading_q <= 1'b0;
         end
      end
   end

   assign code_w_en    = code_w_en_q;
   assign code_addr_in = code_addr_q;
   assign code_in      = code_in_q;
   assign run          = run_q;
   assign loading      = loading_q;
   assign err          = err_q;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: fixed vector table, hand-written
// timing corners, and random frames checked against a frame-level model.
module tb_code_loader;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        code_w_en;
   logic [8:0]  code_addr_in;
   logic [15:0] code_in;
   logic        run;
   logic        loading;
   logic        err;

   always #5 clk = ~clk;

   code_loader #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .code_w_en    (code_w_en),
      .code_addr_in (code_addr_in),
      .code_in      (code_in),
      .run          (run),
      .loading      (loading),
      .err          (err)
   );

   int vec_cnt = 0;
   int miscmp  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Frame-level reference: position within the frame decides a byte's role.
   bit         m_active = 0, m_run = 0, m_err = 0;
   int         m_pos = 0, m_len = 0;
   logic [7:0] m_acc = 0, m_hi = 0;
   bit         e_wen = 0;
   int         e_addr = 0, e_data = 0;

   task automatic model_byte(input logic [7:0] b);
      e_wen = 0;
      if (!m_active) begin
         if (b == 8'hA5) begin
            m_active = 1; m_pos = 0; m_acc = 0; m_run = 0; m_err = 0;
         end
         return;
      end
      m_pos++;
      if (m_pos <= 2) begin
         m_acc ^= b;
         if (m_pos == 1) m_len = int'(b) * 256;
         else begin
            m_len += int'(b);
            if (m_len == 0 || m_len > 512) begin
               m_err = 1; m_active = 0;
            end
         end
      end else if (m_pos <= 2 + 2 * m_len) begin
         m_acc ^= b;
         if (m_pos % 2 == 1) m_hi = b;
         else begin
            e_wen = 1; e_addr = (m_pos - 4) / 2; e_data = int'(m_hi) * 256 + int'(b);
         end
      end else begin
         m_active = 0;
         if (b == m_acc) m_run = 1; else m_err = 1;
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_run = 0; m_err = 0; e_wen = 0;
   endtask

   task automatic expect_outputs(input string tag);
      check({tag, " w_en"}, 32'(code_w_en), 32'(e_wen));
      if (e_wen) begin
         check({tag, " addr"}, 32'(code_addr_in), 32'(e_addr));
         check({tag, " data"}, 32'(code_in), 32'(e_data));
      end
      check({tag, " run"}, 32'(run), 32'(m_run));
      check({tag, " err"}, 32'(err), 32'(m_err));
      check({tag, " loading"}, 32'(loading), 32'(m_active));
   endtask

   // Called at a falling edge; the byte is sampled by the next rising edge.
   task automatic drive_byte(input logic [7:0] b, input string tag);
      rx_valid = 1'b1;
      rx_data  = b;
      model_byte(b);
      @(negedge clk);
      expect_outputs(tag);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check("idle w_en", 32'(code_w_en), 32'd0);
      end
   endtask

   logic [7:0] fq[$];

   task automatic build_frame(input int len16, input bit bad_chk, input int nwords);
      logic [7:0] chk, b;
      fq.delete();
      fq.push_back(8'hA5);
      fq.push_back(8'(len16 >> 8));
      fq.push_back(8'(len16));
      chk = 8'(len16 >> 8) ^ 8'(len16);
      for (int i = 0; i < 2 * nwords; i++) begin
         b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
         fq.push_back(b);
         chk ^= b;
      end
      if (bad_chk) chk ^= 8'($urandom_range(1, 255));
      fq.push_back(chk);
   endtask

   task automatic send_frame(input int maxgap, input string tag);
      foreach (fq[i]) begin
         drive_byte(fq[i], tag);
         if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " w_en"}, 32'(code_w_en), 32'd0);
      check({tag, " addr"}, 32'(code_addr_in), 32'd0);
      check({tag, " data"}, 32'(code_in), 32'd0);
      check({tag, " run"}, 32'(run), 32'd0);
      check({tag, " loading"}, 32'(loading), 32'd0);
      check({tag, " err"}, 32'(err), 32'd0);
   endtask

   typedef struct {
      logic [7:0]  b;
      logic        wen;
      logic [8:0]  addr;
      logic [15:0] data;
      logic        run;
      logic        err;
      logic        load;
   } vec_t;

   vec_t tbl[24];

   function automatic vec_t mk(logic [7:0] b, logic wen, logic [8:0] a, logic [15:0] d,
                               logic r, logic e, logic l);
      vec_t v;
      v.b = b; v.wen = wen; v.addr = a; v.data = d; v.run = r; v.err = e; v.load = l;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      // good frame, same frame with a bad checksum, good frame again
      for (int f = 0; f < 3; f++) begin
         tbl[8*f+0] = mk(8'hA5, 0, 0, 0,        0, 0, 1);
         tbl[8*f+1] = mk(8'h00, 0, 0, 0,        0, 0, 1);
         tbl[8*f+2] = mk(8'h02, 0, 0, 0,        0, 0, 1);
         tbl[8*f+3] = mk(8'h12, 0, 0, 0,        0, 0, 1);
         tbl[8*f+4] = mk(8'h34, 1, 0, 16'h1234, 0, 0, 1);
         tbl[8*f+5] = mk(8'hAB, 0, 0, 0,        0, 0, 1);
         tbl[8*f+6] = mk(8'hCD, 1, 1, 16'hABCD, 0, 0, 1);
         tbl[8*f+7] = mk((f == 1) ? 8'h43 : 8'h42, 0, 0, 0, (f != 1), (f == 1), 0);
      end

      repeat (3) @(negedge clk);
      check_all_zero("in reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("after reset");

      for (int i = 0; i < 24; i++) begin
         rx_valid = 1'b1;
         rx_data  = tbl[i].b;
         model_byte(tbl[i].b);
         @(negedge clk);
         check($sformatf("tbl[%0d] w_en", i), 32'(code_w_en), 32'(tbl[i].wen));
         if (tbl[i].wen) begin
            check($sformatf("tbl[%0d] addr", i), 32'(code_addr_in), 32'(tbl[i].addr));
            check($sformatf("tbl[%0d] data", i), 32'(code_in), 32'(tbl[i].data));
         end
         check($sformatf("tbl[%0d] run", i), 32'(run), 32'(tbl[i].run));
         check($sformatf("tbl[%0d] err", i), 32'(err), 32'(tbl[i].err));
         check($sformatf("tbl[%0d] loading", i), 32'(loading), 32'(tbl[i].load));
      end
      rx_valid = 1'b0;
      idle(2);

      build_frame(0, 0, 0);      send_frame(0, "len0");
      build_frame(16'h0201, 0, 0); send_frame(0, "len513");
      check("len513 err", 32'(err), 32'd1);
      build_frame(16'h0200, 0, 512); send_frame(0, "len512");
      check("len512 run", 32'(run), 32'd1);
      idle(2);

      // timeout fires on idle cycle 16 after the last strobe
      drive_byte(8'hA5, "to"); drive_byte(8'h00, "to");
      drive_byte(8'h01, "to"); drive_byte(8'h12, "to");
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         if (k == TO - 1) check("timeout err at 15", 32'(err), 32'd0);
         if (k == TO) begin
            check("timeout err at 16", 32'(err), 32'd1);
            check("timeout loading", 32'(loading), 32'd0);
         end
      end
      m_active = 0; m_err = 1; m_run = 0;

      // a strobe landing on the expiry edge wins
      drive_byte(8'hA5, "to_avoid"); drive_byte(8'h00, "to_avoid");
      drive_byte(8'h01, "to_avoid"); drive_byte(8'h12, "to_avoid");
      repeat (TO - 1) @(negedge clk);
      drive_byte(8'h34, "to_avoid");
      drive_byte(8'h27, "to_avoid");
      check("to_avoid run", 32'(run), 32'd1);

      // reset in the middle of a frame
      drive_byte(8'hA5, "rst_mid"); drive_byte(8'h00, "rst_mid");
      drive_byte(8'h02, "rst_mid"); drive_byte(8'h12, "rst_mid");
      drive_byte(8'h34, "rst_mid");
      #2 rst_n = 1'b0;
      #1 check_all_zero("async reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive_byte(8'hA5, "post_rst"); drive_byte(8'h00, "post_rst");
      drive_byte(8'h01, "post_rst"); drive_byte(8'h56, "post_rst");
      drive_byte(8'h78, "post_rst");
      check("post_rst addr", 32'(code_addr_in), 32'd0);
      drive_byte(8'h2F, "post_rst");

      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            fq.delete();
            fq.push_back(8'($urandom_range(0, 255)));
            if (fq[0] == 8'hA5) fq[0] = 8'h00;
         end else if (kind == 1) begin
            build_frame(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(513, 65535), 0, 0);
         end else begin
            int len;
            len = $urandom_range(1, 6);
            build_frame(len, (kind == 2), len);
         end
         send_frame(($urandom_range(0, 1) == 0) ? 0 : 3, $sformatf("rand%0d", n));
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule

// File: doc/code_loader.md
# code_loader

Byte-stream program loader that sits directly upstream of the processor datapath's code-memory write port. It accepts framed bytes from a serial receiver, assembles 16-bit instruction words, and writes them sequentially into code memory through `code_w_en`, `code_addr_in` and `code_in`. It verifies an XOR checksum and then asserts `run` to release the processor.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_WORDS`, 512, code memory depth; largest legal length field
- `TIMEOUT`, 1_000_000, max idle clk cycles between bytes inside a frame
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid
- `rx_data`  in  8  received byte
- `code_w_en`  out  1  code memory write strobe, one cycle per word
- `code_addr_in`  out  9  code memory write address
- `code_in`  out  16  code memory write data
- `run`  out  1  processor run enable
- `loading`  out  1  high while a frame is in progress
- `err`  out  1  sticky frame error flag

## Operation
- Frame format: SYNC, LEN_HI, LEN_LO, then LEN words sent high byte first, then CHK.
  - CHK is the 8-bit XOR of every byte after SYNC, excluding CHK itself.
- States:
  - IDLE: waits for SYNC. Non-SYNC bytes are ignored.
  - LEN_HI: captures the upper length byte.
  - LEN_LO: captures the lower length byte. LEN=0 or LEN>MAX_WORDS goes to ERROR.
  - DATA_HI: captures the high byte of a word.
  - DATA_LO: captures the low byte, then issues the write.
  - CHECK: CHK equal to the accumulator goes to DONE; otherwise ERROR.
  - DONE: `run`=1.
  - ERROR: `err`=1, `run`=0.
- Transitions are taken only on `rx_valid`, except the timeout transition.
- A SYNC byte in DONE or ERROR starts a new frame:
  - `run` and `err` clear.
  - The address counter returns to 0.
  - The state goes to LEN_HI.
- A SYNC value inside a frame is ordinary data with no special meaning.
- Word counter (10 bit) and address counter (9 bit):
  - Address increments after each write.
  - After the write of word LEN the state moves to CHECK.
  - The address never wraps, because LEN ≤ 512.
- `loading`=1 in LEN_HI through CHECK.
- Timeout: in LEN_HI through CHECK, an idle counter reaching TIMEOUT goes to ERROR. The counter clears on each `rx_valid`.
- Reset mid-operation: all state returns to IDLE and every output returns to its reset value. Code memory already written is not cleared.

## Timing
- Reset values: `code_w_en`=0, `code_addr_in`=0, `code_in`=0, `run`=0, `loading`=0, `err`=0. State is IDLE.
- All outputs are registered.
- `code_w_en` is high exactly the one cycle after the DATA_LO byte strobe. `code_addr_in` and `code_in` are stable in that cycle and held until the next write.
- Back-to-back `rx_valid`, one byte per cycle, is legal. A write overlaps acceptance of the next byte, so no backpressure is needed.
- `run` rises the cycle after a matching CHK strobe. It falls the cycle after an accepting SYNC strobe.
- `err` rises the cycle after the failing strobe or the timeout expiry.
- `rx_valid` in the same cycle the idle counter reaches TIMEOUT: the byte wins and no error is raised.

## Structure
- The shared constants header holds:
  - SYNC_BYTE default
  - MAX_WORDS
  - the 3-bit state encoding defines: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
- One sub-module, `loader_timer`:
  - Parameterised idle counter with `clear` and `enable` inputs and an `expired` output.
  - Reset is asynchronous, active-low.
- The top-level datapath wires `run` to the control-unit clock gate and muxes `code_addr_in` as it does today.

## Test plan
- Reset check: after reset, confirm all outputs are 0 and `loading`=0.
- Two-word load: send A5 00 02 12 34 AB CD 42, back-to-back.
  - Expect writes addr0=0x1234 and addr1=0xABCD, each `code_w_en` one cycle.
  - Expect `run`=1 one cycle after 42 and `err`=0.
- Bad checksum: the same frame with a final 43 gives both writes, then `err`=1 and `run`=0. A following good frame clears `err` and raises `run`.
- Length limits:
  - LEN=0x0000 gives `err`=1 after LEN_LO with no writes.
  - LEN=0x0201 gives the same.
  - LEN=0x0200 with 1024 bytes and a correct CHK writes addr 0..511 and raises `run`.
- Timeout (TIMEOUT=16): stop after A5 00 01 12. Expect `err`=1 exactly 16 cycles after the last strobe. A strobe arriving on cycle 16 instead avoids the error.
- Reset mid-frame: assert `rst_n`=0 after the first data word is written. Expect outputs to return to 0 immediately and the next frame to load from addr 0.
